// File: rtl/cache_def_pkg.sv
// cache_def: shared L1 geometry and the miss-controller state type.
//   INDEX_L1      set-index width
//   DEPTH_L1      number of sets
//   INDEX_WAY_L1  way-number width (WAYS = 2**INDEX_WAY_L1)
//   TAG_W/LINE_W  tag and cache-line widths
package cache_def;

  localparam int INDEX_L1     = 6;
  localparam int DEPTH_L1     = 1 << INDEX_L1;
  localparam int INDEX_WAY_L1 = 2;
  localparam int TAG_W        = 20;
  localparam int LINE_W       = 128;

  typedef enum logic [2:0] {
    IDLE,
    WB,
    FILL,
    FILL_WAIT,
    REFILL,
    UPDATE
  } miss_state_e;

endpackage

// File: rtl/cache_l1_miss_ctrl_victim_sel.sv
// cache_victim_sel: combinational replacement choice for one set.
//   valid_bits_i  valid bit per way
//   plru_way_i    pLRU replacement hint for the set
//   victim_way_o  lowest-index invalid way, or the pLRU hint when all ways are valid
module cache_victim_sel
  import cache_def::*;
#(
  parameter int WAYS  = 4,
  parameter int WAY_W = INDEX_WAY_L1
) (
  input  logic [WAYS-1:0]  valid_bits_i,
  input  logic [WAY_W-1:0] plru_way_i,
  output logic [WAY_W-1:0] victim_way_o
);

  // Scanning from the top down lets the lowest invalid way win.
  always_comb begin
    victim_way_o = plru_way_i;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_bits_i[w]) victim_way_o = WAY_W'(w);
    end
  end

endmodule

// File: rtl/cache_l1_miss_ctrl.sv
// cache_l1_miss_ctrl: one-request-at-a-time L1 hit/miss sequencer.
//   req_*         core-side request, accepted in IDLE (req_ready_o)
//   hit_*/valid/dirty/way_tags/victim_line/plru_way_i  set state for req_index_i
//   victim_way_o  victim selection (live in IDLE, latched while busy)
//   mem_*         writeback / refill interface
//   arr_*         tag/data array write port (written valid=1, dirty=0)
//   plru_*        pLRU update for the accessed way
//   done_*        completion pulse and serving way
//   *_cnt_o       saturating hit / miss / writeback counters
module cache_l1_miss_ctrl
  import cache_def::*;
#(
  parameter int WAYS    = 4,
  parameter int WAY_W   = INDEX_WAY_L1,
  parameter int INDEX_W = INDEX_L1,
  parameter int TAG_W   = cache_def::TAG_W,
  parameter int LINE_W  = cache_def::LINE_W,
  parameter int CNT_W   = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [INDEX_W-1:0]       req_index_i,
  input  logic [TAG_W-1:0]         req_tag_i,
  input  logic                     hit_i,
  input  logic [WAY_W-1:0]         hit_way_i,
  input  logic [WAYS-1:0]          valid_bits_i,
  input  logic [WAYS-1:0]          dirty_bits_i,
  input  logic [WAYS*TAG_W-1:0]    way_tags_i,
  input  logic [LINE_W-1:0]        victim_line_i,
  output logic [WAY_W-1:0]         victim_way_o,
  input  logic [WAY_W-1:0]         plru_way_i,
  output logic                     plru_valid_o,
  output logic [INDEX_W-1:0]       plru_index_o,
  output logic [WAY_W-1:0]         plru_way_o,
  output logic                     mem_req_o,
  output logic                     mem_we_o,
  output logic [TAG_W+INDEX_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0]        mem_wdata_o,
  input  logic                     mem_ready_i,
  input  logic                     mem_rvalid_i,
  input  logic [LINE_W-1:0]        mem_rdata_i,
  output logic                     arr_we_o,
  output logic [WAY_W-1:0]         arr_way_o,
  output logic [INDEX_W-1:0]       arr_index_o,
  output logic [TAG_W-1:0]         arr_tag_o,
  output logic [LINE_W-1:0]        arr_line_o,
  output logic                     done_o,
  output logic [WAY_W-1:0]         done_way_o,
  output logic [CNT_W-1:0]         hit_cnt_o,
  output logic [CNT_W-1:0]         miss_cnt_o,
  output logic [CNT_W-1:0]         wb_cnt_o
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  miss_state_e        state_q, state_d;
  logic [INDEX_W-1:0] index_q, index_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [WAY_W-1:0]   way_q, way_d;          // way that serves the access
  logic [WAY_W-1:0]   vic_way_q, vic_way_d;
  logic [TAG_W-1:0]   vic_tag_q, vic_tag_d;
  // Holds the victim line until the writeback completes, then the refill data.
  logic [LINE_W-1:0]  line_q, line_d;
  logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;
  logic [CNT_W-1:0]   wb_cnt_q, wb_cnt_d;

  logic [WAY_W-1:0]   sel_way;
  logic [TAG_W-1:0]   sel_tag;

  cache_victim_sel #(
    .WAYS  (WAYS),
    .WAY_W (WAY_W)
  ) u_victim_sel (
    .valid_bits_i (valid_bits_i),
    .plru_way_i   (plru_way_i),
    .victim_way_o (sel_way)
  );

  assign sel_tag = way_tags_i[int'(sel_way)*TAG_W +: TAG_W];

  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    tag_d      = tag_q;
    way_d      = way_q;
    vic_way_d  = vic_way_q;
    vic_tag_d  = vic_tag_q;
    line_d     = line_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    wb_cnt_d   = wb_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          index_d   = req_index_i;
          tag_d     = req_tag_i;
          vic_way_d = sel_way;
          vic_tag_d = sel_tag;
          line_d    = victim_line_i;
          if (hit_i) begin
            way_d     = hit_way_i;
            hit_cnt_d = sat_inc(hit_cnt_q);
            state_d   = UPDATE;
          end else begin
            way_d      = sel_way;
            miss_cnt_d = sat_inc(miss_cnt_q);
            state_d    = dirty_bits_i[sel_way] ? WB : FILL;
          end
        end
      end
      WB: begin
        if (mem_ready_i) begin
          wb_cnt_d = sat_inc(wb_cnt_q);
          state_d  = FILL;
        end
      end
      FILL: begin
        if (mem_ready_i) state_d = FILL_WAIT;
      end
      FILL_WAIT: begin
        if (mem_rvalid_i) begin
          line_d  = mem_rdata_i;
          state_d = REFILL;
        end
      end
      REFILL:  state_d = UPDATE;
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      index_q    <= '0;
      tag_q      <= '0;
      way_q      <= '0;
      vic_way_q  <= '0;
      vic_tag_q  <= '0;
      line_q     <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      tag_q      <= tag_d;
      way_q      <= way_d;
      vic_way_q  <= vic_way_d;
      vic_tag_q  <= vic_tag_d;
      line_q     <= line_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      wb_cnt_q   <= wb_cnt_d;
    end
  end

  // All strobes decode directly from the state register, so an async reset
  // drops them in the same instant.
  assign req_ready_o  = (state_q == IDLE);
  assign victim_way_o = (state_q == IDLE) ? sel_way : vic_way_q;

  assign mem_req_o   = (state_q == WB) || (state_q == FILL);
  assign mem_we_o    = (state_q == WB);
  assign mem_addr_o  = (state_q == WB) ? {vic_tag_q, index_q} : {tag_q, index_q};
  assign mem_wdata_o = (state_q == WB) ? line_q : '0;

  assign arr_we_o    = (state_q == REFILL);
  assign arr_way_o   = way_q;
  assign arr_index_o = index_q;
  assign arr_tag_o   = tag_q;
  assign arr_line_o  = line_q;

  assign plru_valid_o = (state_q == UPDATE);
  assign plru_index_o = index_q;
  assign plru_way_o   = way_q;
  assign done_o       = (state_q == UPDATE);
  assign done_way_o   = way_q;

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
  assign wb_cnt_o   = wb_cnt_q;

endmodule
